// File: rtl/vga_render_pipe_if.sv
// vga_render_pipe_if: pixel stream, per-frame game state and render/collision results.
interface vga_render_pipe_if #(
    parameter int N_OBS = 10,
    parameter int X_W = 10,
    parameter int Y_W = 9,
    parameter int RGB_W = 12
);
    logic pix_valid;
    logic [X_W-1:0] pix_x;
    logic [Y_W-1:0] pix_y;
    logic frame_start;
    logic [1:0] gamemode;
    logic [Y_W-1:0] player_y;
    logic [N_OBS-1:0] obs_en;
    logic [N_OBS-1:0][X_W-1:0] obs_left;
    logic [N_OBS-1:0][X_W-1:0] obs_right;
    logic [N_OBS-1:0][Y_W-1:0] obs_up;
    logic [N_OBS-1:0][Y_W-1:0] obs_down;
    logic [RGB_W-1:0] rgb;
    logic rgb_valid;
    logic collision;
    logic [N_OBS-1:0] hit_mask;
    modport master (
        output pix_valid, pix_x, pix_y, frame_start, gamemode, player_y,
        output obs_en, obs_left, obs_right, obs_up, obs_down,
        input rgb, rgb_valid, collision, hit_mask
    );
    modport slave (
        input pix_valid, pix_x, pix_y, frame_start, gamemode, player_y,
        input obs_en, obs_left, obs_right, obs_up, obs_down,
        output rgb, rgb_valid, collision, hit_mask
    );
endinterface

// File: rtl/vga_render_pipe.sv
// vga_render_pipe: two-stage pixel colouring from per-frame shadowed game state,
// with pause blink and per-frame player/obstacle collision reporting.
module vga_render_pipe #(
    parameter int N_OBS = 10,
    parameter int X_W = 10,
    parameter int Y_W = 9,
    parameter int RGB_W = 12,
    parameter int PLAYER_X = 160,
    parameter int PLAYER_SIZE = 40,
    parameter int UPPER_BOUND = 20,
    parameter int LOWER_BOUND = 460,
    parameter int BLINK_FRAMES = 30,
    parameter logic [RGB_W-1:0] C_BORDER = RGB_W'(12'h000),
    parameter logic [RGB_W-1:0] C_INIT = RGB_W'(12'h0F0),
    parameter logic [RGB_W-1:0] C_GAME = RGB_W'(12'hFFF),
    parameter logic [RGB_W-1:0] C_PAUSE = RGB_W'(12'hFF0),
    parameter logic [RGB_W-1:0] C_END = RGB_W'(12'hF00),
    parameter logic [RGB_W-1:0] C_OBS = RGB_W'(12'hFA0),
    parameter logic [RGB_W-1:0] C_PLAYER = RGB_W'(12'h00F)
) (
    input logic clk,
    input logic rst,
    vga_render_pipe_if.slave bus
);
    localparam int BW = $clog2(BLINK_FRAMES + 1);
    localparam logic [BW-1:0] BLAST = BW'(BLINK_FRAMES - 1);
    localparam logic [X_W-1:0] PX_LO = X_W'(PLAYER_X);
    localparam logic [X_W-1:0] PX_HI = X_W'(PLAYER_X + PLAYER_SIZE);
    localparam logic [Y_W:0] PSZ = (Y_W + 1)'(PLAYER_SIZE);
    localparam logic [Y_W-1:0] UB = Y_W'(UPPER_BOUND);
    localparam logic [Y_W-1:0] LB = Y_W'(LOWER_BOUND);

    logic [1:0] mode_q;
    logic [Y_W-1:0] py_q;
    logic [N_OBS-1:0] en_q;
    logic [N_OBS-1:0][X_W-1:0] left_q, right_q;
    logic [N_OBS-1:0][Y_W-1:0] up_q, down_q;
    logic [BW-1:0] cnt_q, cnt_d;
    logic phase_q, phase_d;
    logic [N_OBS-1:0] acc_q, acc_d, hit_mask_q;
    logic collision_q;
    logic v1_q, border1_q, pl1_q, ob1_q;
    logic [1:0] bg1_q;
    logic [RGB_W-1:0] rgb_q, rgb_d;
    logic rgb_valid_q;

    logic border, player, paused, wrap, draw_pl, draw_ob;
    logic [Y_W:0] py_end;
    logic [N_OBS-1:0] obs_hit, acc_set;

    assign border = bus.pix_y <= UB || bus.pix_y >= LB;
    assign py_end = {1'b0, py_q} + PSZ;
    assign player = bus.pix_x >= PX_LO && bus.pix_x < PX_HI &&
                    bus.pix_y >= py_q && {1'b0, bus.pix_y} < py_end;

    // Empty or inverted bounds fall out of the half-open compares as no hit.
    for (genvar i = 0; i < N_OBS; i++) begin : g_obs
        assign obs_hit[i] = en_q[i] && bus.pix_x >= left_q[i] && bus.pix_x < right_q[i] &&
                            bus.pix_y >= up_q[i] && bus.pix_y < down_q[i];
    end

    assign paused = mode_q == 2'b10;
    assign wrap = cnt_q == BLAST;
    assign cnt_d = !paused ? '0 : bus.frame_start ? (wrap ? '0 : cnt_q + BW'(1)) : cnt_q;
    assign phase_d = paused && (phase_q ^ (bus.frame_start && wrap));
    assign draw_pl = player && mode_q != 2'b00 && !(paused && phase_q);
    assign draw_ob = |obs_hit && mode_q != 2'b00;
    assign acc_set = (mode_q == 2'b01 && bus.pix_valid && !border && player) ? obs_hit : '0;
    assign acc_d = (bus.frame_start ? '0 : acc_q) | acc_set;
    assign rgb_d = !v1_q ? '0 : border1_q ? C_BORDER : pl1_q ? C_PLAYER : ob1_q ? C_OBS :
                   bg1_q == 2'b00 ? C_INIT : bg1_q == 2'b01 ? C_GAME :
                   bg1_q == 2'b10 ? C_PAUSE : C_END;

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= '0;
            py_q <= '0;
            en_q <= '0;
            left_q <= '0;
            right_q <= '0;
            up_q <= '0;
            down_q <= '0;
            cnt_q <= '0;
            phase_q <= 1'b0;
            acc_q <= '0;
            hit_mask_q <= '0;
            collision_q <= 1'b0;
            v1_q <= 1'b0;
            border1_q <= 1'b0;
            pl1_q <= 1'b0;
            ob1_q <= 1'b0;
            bg1_q <= '0;
            rgb_q <= '0;
            rgb_valid_q <= 1'b0;
        end else begin
            if (bus.frame_start) begin
                mode_q <= bus.gamemode;
                py_q <= bus.player_y;
                en_q <= bus.obs_en;
                left_q <= bus.obs_left;
                right_q <= bus.obs_right;
                up_q <= bus.obs_up;
                down_q <= bus.obs_down;
                hit_mask_q <= acc_q;
            end
            collision_q <= bus.frame_start && |acc_q;
            cnt_q <= cnt_d;
            phase_q <= phase_d;
            acc_q <= acc_d;
            v1_q <= bus.pix_valid;
            border1_q <= border;
            pl1_q <= draw_pl;
            ob1_q <= draw_ob;
            bg1_q <= mode_q;
            rgb_q <= rgb_d;
            rgb_valid_q <= v1_q;
        end
    end

    assign bus.rgb = rgb_q;
    assign bus.rgb_valid = rgb_valid_q;
    assign bus.collision = collision_q;
    assign bus.hit_mask = hit_mask_q;
endmodule

// File: tb/tb_vga_render_pipe.sv
// tb_vga_render_pipe: table vectors, directed corner sequences and random frames
// checked against a frame-level reference model.
module tb_vga_render_pipe;
    localparam int N = 10;
    localparam int BF = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vga_render_pipe_if bus ();
    vga_render_pipe #(.BLINK_FRAMES(BF)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        int x;
        int y;
        logic [11:0] rgb;
    } vec_t;

    int errs = 0;
    int checks = 0;

    int m_mode, m_py, pause_cnt;
    bit m_en[N];
    int m_l[N], m_r[N], m_u[N], m_d[N];
    logic [N-1:0] m_acc, e_mask;
    logic e_col;
    logic [12:0] e_s1, e_out;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s @%0t: got %h want %h", nm, $time, act, exp);
        end
    endtask

    function automatic bit in_player(int x, int y);
        return x >= 160 && x < 200 && y >= m_py && y < m_py + 40;
    endfunction

    function automatic bit in_obs(int i, int x, int y);
        return m_en[i] && x >= m_l[i] && x < m_r[i] && y >= m_u[i] && y < m_d[i];
    endfunction

    function automatic logic [11:0] ref_colour(int x, int y);
        bit ob = 0;
        bit blink = m_mode == 2 && (pause_cnt / BF) % 2 == 1;
        for (int i = 0; i < N; i++) ob |= in_obs(i, x, y);
        if (y <= 20 || y >= 460) return 12'h000;
        if (m_mode == 0) return 12'h0F0;
        if (in_player(x, y) && !blink) return 12'h00F;
        if (ob) return 12'hFA0;
        return m_mode == 1 ? 12'hFFF : m_mode == 2 ? 12'hFF0 : 12'hF00;
    endfunction

    function automatic logic [N-1:0] ref_hits(int x, int y);
        logic [N-1:0] h = '0;
        if (m_mode != 1 || y <= 20 || y >= 460 || !in_player(x, y)) return h;
        for (int i = 0; i < N; i++) h[i] = in_obs(i, x, y);
        return h;
    endfunction

    task automatic tick();
        logic [12:0] nw;
        logic [N-1:0] hits;
        nw = bus.pix_valid ? {1'b1, ref_colour(int'(bus.pix_x), int'(bus.pix_y))} : 13'd0;
        hits = bus.pix_valid ? ref_hits(int'(bus.pix_x), int'(bus.pix_y)) : '0;
        @(posedge clk);
        #1;
        if (rst) begin
            e_out = '0; e_s1 = '0; e_col = 0; e_mask = '0; m_acc = '0;
            pause_cnt = 0; m_mode = 0; m_py = 0;
            for (int i = 0; i < N; i++) begin
                m_en[i] = 0; m_l[i] = 0; m_r[i] = 0; m_u[i] = 0; m_d[i] = 0;
            end
        end else begin
            e_out = e_s1;
            e_s1 = nw;
            e_col = bus.frame_start && m_acc != 0;
            if (bus.frame_start) begin
                e_mask = m_acc;
                m_acc = hits;
                pause_cnt = m_mode == 2 ? pause_cnt + 1 : 0;
                m_mode = int'(bus.gamemode);
                m_py = int'(bus.player_y);
                for (int i = 0; i < N; i++) begin
                    m_en[i] = bus.obs_en[i];
                    m_l[i] = int'(bus.obs_left[i]);
                    m_r[i] = int'(bus.obs_right[i]);
                    m_u[i] = int'(bus.obs_up[i]);
                    m_d[i] = int'(bus.obs_down[i]);
                end
            end else begin
                m_acc |= hits;
            end
        end
        chk("pixel", 32'({bus.rgb_valid, bus.rgb}), 32'(e_out));
        chk("collide", 32'({bus.collision, bus.hit_mask}), 32'({e_col, e_mask}));
    endtask

    task automatic pixel(int x, int y);
        bus.pix_valid = 1'b1;
        bus.pix_x = 10'(x);
        bus.pix_y = 9'(y);
    endtask

    task automatic idle();
        bus.pix_valid = 1'b0;
    endtask

    task automatic set_obs(int i, bit en, int l, int r, int u, int d);
        bus.obs_en[i] = en;
        bus.obs_left[i] = 10'(l);
        bus.obs_right[i] = 10'(r);
        bus.obs_up[i] = 9'(u);
        bus.obs_down[i] = 9'(d);
    endtask

    task automatic frame(logic [1:0] gm, int py);
        bus.frame_start = 1'b1;
        bus.gamemode = gm;
        bus.player_y = 9'(py);
        tick();
        bus.frame_start = 1'b0;
    endtask

    task automatic render(string nm, int x, int y, logic [11:0] want);
        pixel(x, y);
        tick();
        idle();
        tick();
        chk(nm, 32'({bus.rgb_valid, bus.rgb}), 32'({1'b1, want}));
    endtask

    vec_t vecs[14];

    initial begin
        vecs[0] = '{300, 100, 12'hFA0};
        vecs[1] = '{340, 100, 12'hFFF};
        vecs[2] = '{310, 20, 12'h000};
        vecs[3] = '{339, 149, 12'hFA0};
        vecs[4] = '{339, 150, 12'hFFF};
        vecs[5] = '{299, 120, 12'hFFF};
        vecs[6] = '{310, 460, 12'h000};
        vecs[7] = '{310, 459, 12'hFFF};
        vecs[8] = '{170, 210, 12'h00F};
        vecs[9] = '{155, 210, 12'hFA0};
        vecs[10] = '{199, 239, 12'h00F};
        vecs[11] = '{200, 239, 12'hFFF};
        vecs[12] = '{170, 240, 12'hFA0};
        vecs[13] = '{310, 21, 12'hFFF};

        bus.pix_valid = 0; bus.pix_x = '0; bus.pix_y = '0; bus.frame_start = 0;
        bus.gamemode = 2'b00; bus.player_y = '0;
        for (int i = 0; i < N; i++) set_obs(i, 0, 0, 0, 0, 0);
        rst = 1'b1;
        repeat (3) tick();
        chk("reset", 32'({bus.rgb_valid, bus.rgb, bus.collision, bus.hit_mask}), 32'd0);
        rst = 1'b0;

        // Shadow mode is still init: no player, border still drawn.
        render("init_player", 170, 210, 12'h0F0);
        render("init_border", 170, 10, 12'h000);

        frame(2'b01, 200);
        render("player", 170, 210, 12'h00F);

        set_obs(3, 1, 300, 340, 100, 150);
        set_obs(5, 1, 150, 180, 190, 260);
        frame(2'b01, 200);
        for (int k = 0; k < 14; k++)
            render($sformatf("vec%0d", k), vecs[k].x, vecs[k].y, vecs[k].rgb);

        for (int i = 0; i < N; i++) set_obs(i, 0, 0, 0, 0, 0);
        set_obs(0, 1, 150, 170, 100, 120);
        frame(2'b01, 100);
        render("hit_pix", 165, 110, 12'h00F);
        tick();
        set_obs(0, 0, 150, 170, 100, 120);
        frame(2'b01, 100);
        chk("hit_report", 32'({bus.collision, bus.hit_mask}), 32'({1'b1, 10'b1}));
        tick();
        chk("hit_pulse_end", 32'({bus.collision, bus.hit_mask}), 32'({1'b0, 10'b1}));
        render("nohit_pix", 165, 110, 12'h00F);
        frame(2'b01, 100);
        chk("nohit_report", 32'({bus.collision, bus.hit_mask}), 32'd0);

        for (int f = 0; f < 6; f++) begin
            frame(2'b10, 200);
            render($sformatf("blink%0d", f), 170, 210, (f / 2) % 2 == 1 ? 12'hFF0 : 12'h00F);
            tick();
        end

        frame(2'b01, 200);
        bus.player_y = 9'd300;
        render("stale_py_old", 170, 210, 12'h00F);
        render("stale_py_new", 170, 310, 12'hFFF);
        frame(2'b01, 300);
        render("fresh_py", 170, 310, 12'h00F);

        // Reset with a pixel in each pipeline stage.
        pixel(170, 310);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rel0", 32'({bus.rgb_valid, bus.rgb}), 32'd0);
        tick();
        chk("rel1", 32'({bus.rgb_valid, bus.rgb}), 32'd0);
        tick();
        chk("rel2", 32'({bus.rgb_valid, bus.rgb}), 32'({1'b1, 12'h0F0}));

        for (int f = 0; f < 30; f++) begin
            int py = $urandom_range(0, 511);
            for (int i = 0; i < N; i++) begin
                int l = $urandom_range(120, 260);
                int r = l + $urandom_range(0, 50);
                int u = (py + $urandom_range(0, 60)) % 512;
                int d = u + $urandom_range(0, 40);
                if ($urandom % 8 == 0) begin
                    int t = l; l = r; r = t;
                end
                set_obs(i, 1'($urandom), l, r, u, d > 511 ? 511 : d);
            end
            bus.pix_valid = 1'($urandom);
            frame(($urandom % 2 == 1) ? 2'b01 : 2'($urandom_range(0, 3)), py);
            repeat (60) begin
                if ($urandom % 5 == 0) pixel($urandom_range(0, 639), $urandom_range(0, 479));
                else pixel($urandom_range(140, 230), (py + $urandom_range(0, 60)) % 512);
                bus.pix_valid = ($urandom % 4) != 0;
                tick();
            end
            // A frame boundary with a live hit-capable pixel in the same cycle.
            pixel($urandom_range(160, 199), (py + $urandom_range(0, 39)) % 512);
            bus.frame_start = 1'b1;
            tick();
            bus.frame_start = 1'b0;
        end
        idle();
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
